// File: rtl/i2c_controller.sv
// Single-master I2C initiator: one START / address+R/W / ACK / data byte / ACK / STOP
// transaction per accepted request, driving open-drain SCL and SDA enables.
module i2c_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_ADDR_ACK = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_DATA_ACK = 3'd5;
  localparam logic [2:0] S_STOP     = 3'd6;

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       quarter_q, quarter_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rw_q, rw_d;
  logic             sample_q, sample_d;
  logic             busy_q, done_q, done_d;
  logic             ack_error_q, ack_error_d;
  logic             sda_oe_q, scl_oe_q;
  logic             tick;

  // Bus enables {scl_oe, sda_oe} for a given position inside a bit slot.
  function automatic logic [1:0] bus_drive(input logic [2:0] st, input logic [1:0] q,
                                           input logic rd, input logic bit_val);
    logic scl_low;
    scl_low = (q == 2'd0) || (q == 2'd3);
    case (st)
      S_START:                return {1'b0, q[1]};
      S_ADDR:                 return {scl_low, ~bit_val};
      S_DATA:                 return {scl_low, ~rd & ~bit_val};
      S_ADDR_ACK, S_DATA_ACK: return {scl_low, 1'b0};
      S_STOP:                 return {q == 2'd0, ~q[1]};
      default:                return 2'b00;
    endcase
  endfunction

  assign tick = (state_q != S_IDLE) && (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    div_d       = div_q;
    quarter_d   = quarter_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rw_d        = rw_q;
    sample_d    = sample_q;
    ack_error_d = ack_error_q;
    done_d      = 1'b0;

    if (state_q == S_IDLE) begin
      div_d     = '0;
      quarter_d = 2'd0;
      bit_d     = 3'd0;
      if (start) begin
        state_d     = S_START;
        shift_d     = {addr, rw};
        rw_d        = rw;
        wdata_d     = wdata;
        ack_error_d = 1'b0;
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        quarter_d = quarter_q + 2'd1;
        if (quarter_q == 2'd1) sample_d = sda_in;
        // Bit-slot bookkeeping happens on the last quarter so SDA only moves in Q0.
        if (quarter_q == 2'd3) begin
          case (state_q)
            S_START: state_d = S_ADDR;
            S_ADDR: begin
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
              if (sample_q) begin
                ack_error_d = 1'b1;
                state_d     = S_STOP;
              end else begin
                state_d = S_DATA;
                shift_d = rw_q ? 8'h00 : wdata_q;
              end
            end
            S_DATA: begin
              shift_d = {shift_q[6:0], sample_q};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = S_DATA_ACK;
            end
            S_DATA_ACK: begin
              if (!rw_q && sample_q) ack_error_d = 1'b1;
              state_d = S_STOP;
            end
            S_STOP: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              if (rw_q && !ack_error_q) rdata_d = shift_q;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      quarter_q   <= 2'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      rw_q        <= 1'b0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q     <= state_d;
      div_q       <= div_d;
      quarter_q   <= quarter_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rw_q        <= rw_d;
      sample_q    <= sample_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
      ack_error_q <= ack_error_d;
      // Pad enables are registered from next-state so they stay aligned with state_q.
      {scl_oe_q, sda_oe_q} <= bus_drive(state_d, quarter_d, rw_d, shift_d[7]);
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;
  assign sda_oe    = sda_oe_q;
  assign scl_oe    = scl_oe_q;

endmodule

// File: tb/tb_i2c_controller.sv
// Scoreboard bench for i2c_controller: two instances (CLK_DIV 4 and 1), each with a
// cycle-sampled bus monitor and target model; done pulses are checked against a queue.
module tb_i2c_controller;

  localparam int NI     = 2;
  localparam int PERIOD = 10;

  typedef struct {
    int         inst;
    string      name;
    logic [7:0] addr_byte;
    logic       addr_ack;
    int         nbits;
    logic [7:0] data_byte;
    logic       data_ack;
    logic       ack_error;
    logic [7:0] rdata;
    int         cycles;
  } exp_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [NI-1:0] start_s = '0;
  logic [NI-1:0] rw_s    = '0;
  logic [6:0]    addr_s  [NI];
  logic [7:0]    wdata_s [NI];
  logic [7:0]    rdata_w [NI];
  logic [NI-1:0] busy_w, done_w, ackerr_w, sda_oe_w, scl_oe_w, sda_in_w;

  logic [NI-1:0] tgt_present   = '1;
  logic [NI-1:0] tgt_nack_data = '0;
  logic [6:0]    tgt_addr  [NI];
  logic [7:0]    tgt_rbyte [NI];
  bit            mon_en = 1'b1;
  longint        t_acc    [NI];
  int            done_cnt [NI];
  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #(PERIOD/2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_bus
    localparam int DIV = (g == 0) ? 4 : 1;
    logic        tgt_pull = 1'b0;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    bit          in_txn = 1'b0, sel = 1'b0, rd = 1'b0;
    int          nb = 0, rec_nbits = 0;
    logic [17:0] bits = '0, rec_bits = '0;
    exp_t        e;
    wire         scl_line = ~scl_oe_w[g];
    wire         sda_line = ~(sda_oe_w[g] | tgt_pull);

    assign sda_in_w[g] = sda_line;

    i2c_controller #(.CLK_DIV(DIV)) u_dut (
      .clk(clk), .reset(reset), .start(start_s[g]), .rw(rw_s[g]),
      .addr(addr_s[g]), .wdata(wdata_s[g]), .rdata(rdata_w[g]),
      .busy(busy_w[g]), .done(done_w[g]), .ack_error(ackerr_w[g]),
      .sda_in(sda_in_w[g]), .sda_oe(sda_oe_w[g]), .scl_oe(scl_oe_w[g])
    );

    always @(posedge clk) begin
      #1;
      if (!mon_en) begin
        in_txn = 1'b0; nb = 0; sel = 1'b0; tgt_pull = 1'b0;
      end else if (prev_scl && scl_line && (prev_sda != sda_line)) begin
        // SDA moving while SCL stays high is only legal as START or STOP.
        if (!sda_line) begin
          check($sformatf("bus%0d_start_order", g), 32'(in_txn), 32'd0);
          in_txn = 1'b1; nb = 0; sel = 1'b0; bits = '0;
        end else begin
          check($sformatf("bus%0d_stop_order", g), 32'(in_txn), 32'd1);
          rec_nbits = nb - 1;
          rec_bits  = bits;
          in_txn = 1'b0; sel = 1'b0; tgt_pull = 1'b0;
        end
      end else if (!prev_scl && scl_line && in_txn) begin
        if (nb < 18) bits[17 - nb] = sda_line;
        nb++;
      end else if (prev_scl && !scl_line && in_txn) begin
        if (nb == 8) begin
          sel      = tgt_present[g] && (bits[17:11] == tgt_addr[g]);
          rd       = bits[10];
          tgt_pull = sel;
        end else if (sel && rd && nb >= 9 && nb <= 16) begin
          tgt_pull = ~tgt_rbyte[g][16 - nb];
        end else if (sel && !rd && nb == 17) begin
          tgt_pull = ~tgt_nack_data[g];
        end else begin
          tgt_pull = 1'b0;
        end
      end
      prev_scl = scl_line;
      prev_sda = sda_line;

      if (done_w[g]) begin
        done_cnt[g]++;
        if (sb_q.size() == 0) begin
          check($sformatf("dut%0d_unexpected_done", g), 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_instance"}, 32'(g), 32'(e.inst));
          check({e.name, "_rdata"}, 32'(rdata_w[g]), 32'(e.rdata));
          check({e.name, "_ack_error"}, 32'(ackerr_w[g]), 32'(e.ack_error));
          check({e.name, "_busy_at_done"}, 32'(busy_w[g]), 32'd0);
          check({e.name, "_bus_idle"}, {30'd0, scl_oe_w[g], sda_oe_w[g]}, 32'd0);
          check({e.name, "_cycles"}, 32'(($time - 1 - t_acc[g]) / PERIOD), 32'(e.cycles));
          check({e.name, "_bus_bits"}, 32'(rec_nbits), 32'(e.nbits));
          check({e.name, "_addr_byte"}, 32'(rec_bits[17:10]), 32'(e.addr_byte));
          check({e.name, "_addr_ack"}, 32'(rec_bits[9]), 32'(e.addr_ack));
          if (e.nbits == 18) begin
            check({e.name, "_data_byte"}, 32'(rec_bits[8:1]), 32'(e.data_byte));
            check({e.name, "_data_ack"}, 32'(rec_bits[0]), 32'(e.data_ack));
          end
        end
      end
    end
  end

  function automatic exp_t mk(input int inst, input string name, input logic [7:0] ab,
                              input logic aa, input int nbits, input logic [7:0] db,
                              input logic da, input logic ae, input logic [7:0] rd, input int cyc);
    exp_t e;
    e.inst = inst; e.name = name; e.addr_byte = ab; e.addr_ack = aa; e.nbits = nbits;
    e.data_byte = db; e.data_ack = da; e.ack_error = ae; e.rdata = rd; e.cycles = cyc;
    return e;
  endfunction

  task automatic issue(input exp_t e, input logic rw, input logic [6:0] a, input logic [7:0] wd);
    sb_q.push_back(e);
    @(negedge clk);
    rw_s[e.inst] = rw; addr_s[e.inst] = a; wdata_s[e.inst] = wd; start_s[e.inst] = 1'b1;
    @(posedge clk);
    t_acc[e.inst] = $time;
    #1;
    start_s[e.inst] = 1'b0;
    check({e.name, "_busy_after_accept"}, 32'(busy_w[e.inst]), 32'd1);
    check({e.name, "_ack_error_cleared"}, 32'(ackerr_w[e.inst]), 32'd0);
  endtask

  task automatic wait_done(input string name);
    int waited = 0;
    while (sb_q.size() != 0 && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    #2;
    check({name, "_done_seen"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    int dc;
    for (int i = 0; i < NI; i++) begin
      addr_s[i] = 7'h00; wdata_s[i] = 8'h00; tgt_addr[i] = 7'h2A; tgt_rbyte[i] = 8'h00; t_acc[i] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset%0d_sda_oe", i), 32'(sda_oe_w[i]), 32'd0);
      check($sformatf("reset%0d_scl_oe", i), 32'(scl_oe_w[i]), 32'd0);
      check($sformatf("reset%0d_busy", i), 32'(busy_w[i]), 32'd0);
      check($sformatf("reset%0d_done", i), 32'(done_w[i]), 32'd0);
      check($sformatf("reset%0d_ack_error", i), 32'(ackerr_w[i]), 32'd0);
      check($sformatf("reset%0d_rdata", i), 32'(rdata_w[i]), 32'd0);
    end
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);

    issue(mk(0, "write_2a_42", 8'h54, 1'b0, 18, 8'h42, 1'b0, 1'b0, 8'h00, 320), 1'b0, 7'h2A, 8'h42);
    wait_done("write_2a_42");

    tgt_rbyte[0] = 8'hA5;
    issue(mk(0, "read_2a_a5", 8'h55, 1'b0, 18, 8'hA5, 1'b1, 1'b0, 8'hA5, 320), 1'b1, 7'h2A, 8'h00);
    wait_done("read_2a_a5");

    tgt_present[0] = 1'b0;
    issue(mk(0, "addr_nack", 8'h55, 1'b1, 9, 8'h00, 1'b0, 1'b1, 8'hA5, 176), 1'b1, 7'h2A, 8'h00);
    wait_done("addr_nack");
    tgt_present[0] = 1'b1;

    tgt_nack_data[0] = 1'b1;
    issue(mk(0, "data_nack", 8'h54, 1'b0, 18, 8'h3C, 1'b1, 1'b1, 8'hA5, 320), 1'b0, 7'h2A, 8'h3C);
    wait_done("data_nack");
    tgt_nack_data[0] = 1'b0;

    issue(mk(0, "write_after_nack", 8'h54, 1'b0, 18, 8'h81, 1'b0, 1'b0, 8'hA5, 320), 1'b0, 7'h2A, 8'h81);
    wait_done("write_after_nack");

    issue(mk(0, "ignored_start", 8'h54, 1'b0, 18, 8'h99, 1'b0, 1'b0, 8'hA5, 320), 1'b0, 7'h2A, 8'h99);
    repeat (100) @(posedge clk);
    @(negedge clk);
    addr_s[0] = 7'h11; wdata_s[0] = 8'h00; rw_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    wait_done("ignored_start");
    repeat (20) @(posedge clk);
    #1;
    check("ignored_start_no_second_txn", 32'(busy_w[0]), 32'd0);

    // Abort a transaction while SCL is held low inside the address byte.
    @(negedge clk);
    rw_s[0] = 1'b0; addr_s[0] = 7'h2A; wdata_s[0] = 8'h42; start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    repeat (44) @(posedge clk);
    mon_en = 1'b0;
    dc = done_cnt[0];
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("midaddr_reset_sda_oe", 32'(sda_oe_w[0]), 32'd0);
    check("midaddr_reset_scl_oe", 32'(scl_oe_w[0]), 32'd0);
    check("midaddr_reset_busy", 32'(busy_w[0]), 32'd0);
    check("midaddr_reset_done", 32'(done_w[0]), 32'd0);
    check("midaddr_reset_rdata", 32'(rdata_w[0]), 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("midaddr_reset_no_done", 32'(done_cnt[0] - dc), 32'd0);
    mon_en = 1'b1;
    repeat (4) @(posedge clk);

    issue(mk(0, "write_after_reset", 8'h54, 1'b0, 18, 8'h5A, 1'b0, 1'b0, 8'h00, 320), 1'b0, 7'h2A, 8'h5A);
    wait_done("write_after_reset");

    tgt_addr[1] = 7'h7F;
    issue(mk(1, "div1_write_7f_ff", 8'hFE, 1'b0, 18, 8'hFF, 1'b0, 1'b0, 8'h00, 80), 1'b0, 7'h7F, 8'hFF);
    wait_done("div1_write_7f_ff");

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
